// File: rtl/sap_ram_arbiter_if.sv
// Loader handshake and memory-pin bundle shared by the SAP-1 RAM arbiter and its environment.
// master: loader and memory side; slave: the arbiter.
interface sap_ram_arbiter_if;
    logic       ld_valid;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram_rdata;

    modport master (
        output ld_valid, ld_addr, ld_data, ram_rdata,
        input  ld_ready, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ram_rdata,
        output ld_ready, ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/sap_ram_arbiter.sv
// SAP-1 16x8 memory arbiter: the CPU reads in RUN, the loader writes in PROG,
// with a drain phase before loading and a hold-release phase after it.
module sap_ram_arbiter #(
    parameter int unsigned RELEASE_CYCLES = 2,
    parameter int unsigned DRAIN_TIMEOUT  = 8
) (
    input  logic                  CLK,
    input  logic                  CLR_bar,
    input  logic                  prog_mode,
    input  logic [3:0]            cpu_addr,
    input  logic                  cpu_CE_bar,
    output logic [7:0]            cpu_data,
    output logic                  cpu_hold_bar,
    sap_ram_arbiter_if.slave      bus,
    output logic [7:0]            checksum,
    output logic [4:0]            words_loaded,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_PROG    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] DRAIN_LAST   = 4'(DRAIN_TIMEOUT - 1);
    localparam logic [3:0] RELEASE_LAST = 4'(RELEASE_CYCLES - 1);
    localparam logic [4:0] WORDS_MAX    = 5'd31;

    logic [1:0] state_q;
    logic [3:0] drain_cnt;
    logic [3:0] release_cnt;
    logic [7:0] sum_q;
    logic [4:0] count_q;
    logic       write_accept;

    assign write_accept = bus.ld_valid && bus.ld_ready;

    // Mode sequencing; session bookkeeping clears on entry to PROG and then
    // stays frozen through RELEASE and RUN so the result can be read back.
    always_ff @(posedge CLK or negedge CLR_bar) begin
        if (!CLR_bar) begin
            state_q     <= ST_RUN;
            drain_cnt   <= '0;
            release_cnt <= '0;
            sum_q       <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (prog_mode) begin
                        state_q   <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (cpu_CE_bar || drain_cnt == DRAIN_LAST) begin
                        state_q <= ST_PROG;
                        sum_q   <= '0;
                        count_q <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                ST_PROG: begin
                    if (write_accept) begin
                        sum_q <= sum_q + bus.ld_data;
                        if (count_q != WORDS_MAX) begin
                            count_q <= count_q + 5'd1;
                        end
                    end
                    if (!prog_mode) begin
                        state_q     <= ST_RELEASE;
                        release_cnt <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (release_cnt == RELEASE_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        release_cnt <= release_cnt + 4'd1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // The read path stays open through DRAIN so an in-flight CPU fetch completes.
    assign cpu_hold_bar  = (state_q == ST_RUN);
    assign bus.ld_ready  = (state_q == ST_PROG);
    assign bus.ram_addr  = (state_q == ST_PROG) ? bus.ld_addr : cpu_addr;
    assign bus.ram_wdata = bus.ld_data;
    assign bus.ram_we    = write_accept;
    assign cpu_data      = ((state_q == ST_RUN || state_q == ST_DRAIN) && !cpu_CE_bar)
                           ? bus.ram_rdata : 8'h00;

    assign checksum     = sum_q;
    assign words_loaded = count_q;
    assign state        = state_q;

endmodule
